// File: rtl/step_controller.sv
// Turns rising edges of the slow divided clock into one-cycle processor enables,
// with a debounced push-button single-step mode and a sticky halt.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int STEP_W          = 16
) (
    input  logic              CLOCK_50,
    input  logic              Key,
    input  logic              divclock,
    input  logic              step_key,
    input  logic              mode,
    input  logic              halt,
    output logic              proc_en,
    output logic [STEP_W-1:0] step_count,
    output logic [3:0]        LEDR
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              div_d1_q, div_d2_q, div_p_q;
    logic              tick;
    logic              key_d1_q, key_s_q, key_stable_q, key_stable_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stable_d;
    logic              press;
    state_t            state_q;
    logic              proc_en_q;
    logic [STEP_W-1:0] step_count_q;

    // divclock is treated as asynchronous data: two flops, then an edge detect.
    always_ff @(posedge CLOCK_50 or negedge Key) begin
        if (!Key) begin
            div_d1_q <= 1'b0;
            div_d2_q <= 1'b0;
            div_p_q  <= 1'b0;
        end else begin
            div_d1_q <= divclock;
            div_d2_q <= div_d1_q;
            div_p_q  <= div_d2_q;
        end
    end

    assign tick = div_d2_q & ~div_p_q;

    // Any return to the accepted level restarts the hold count.
    always_comb begin
        cnt_d    = '0;
        stable_d = key_stable_q;
        if (key_s_q != key_stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = key_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Key) begin
        if (!Key) begin
            key_d1_q          <= 1'b1;
            key_s_q           <= 1'b1;
            key_stable_q      <= 1'b1;
            key_stable_prev_q <= 1'b1;
            cnt_q             <= '0;
        end else begin
            key_d1_q          <= step_key;
            key_s_q           <= key_d1_q;
            key_stable_q      <= stable_d;
            key_stable_prev_q <= key_stable_q;
            cnt_q             <= cnt_d;
        end
    end

    assign press = key_stable_prev_q & ~key_stable_q;

    always_ff @(posedge CLOCK_50 or negedge Key) begin
        if (!Key) begin
            state_q      <= ST_STOP;
            proc_en_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            proc_en_q <= 1'b0;
            case (state_q)
                ST_STOP: begin
                    if (mode && !halt) begin
                        state_q <= ST_RUN;
                    end else if (press) begin
                        proc_en_q    <= 1'b1;
                        step_count_q <= step_count_q + STEP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q <= ST_HALT;
                    end else if (!mode) begin
                        state_q <= ST_STOP;
                    end else if (tick) begin
                        proc_en_q    <= 1'b1;
                        step_count_q <= step_count_q + STEP_W'(1);
                    end
                end
                ST_HALT: begin
                    // Halt is sticky: only leaving run mode releases it.
                    if (!mode) begin
                        state_q <= ST_STOP;
                    end
                end
                default: state_q <= ST_STOP;
            endcase
        end
    end

    assign proc_en    = proc_en_q;
    assign step_count = step_count_q;
    assign LEDR       = {div_d2_q, key_stable_q, state_q};

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: every expected proc_en pulse is queued with its
// step_count value when stimulus is driven and popped when the pulse appears.
module tb_step_controller;

  localparam int DEB    = 4;
  localparam int CNT_W  = 3;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              Key, divclock, step_key, mode, halt;
  logic              proc_en;
  logic [STEP_W-1:0] step_count;
  logic [3:0]        LEDR;

  int errors = 0;
  int checks = 0;

  logic [STEP_W-1:0] exp_q[$];
  logic [STEP_W-1:0] model_cnt = '0;
  logic [STEP_W-1:0] mon_exp;
  logic              prev_pe = 1'b0;

  step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W),
    .STEP_W(STEP_W)
  ) dut (
    .CLOCK_50(clk),
    .Key(Key),
    .divclock(divclock),
    .step_key(step_key),
    .mode(mode),
    .halt(halt),
    .proc_en(proc_en),
    .step_count(step_count),
    .LEDR(LEDR)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard: every observed pulse must match the head of the expected queue
  always @(posedge clk) begin
    #2;
    if (proc_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: proc_en=1 step_count=%0d, required no pulse", step_count);
      end else begin
        mon_exp = exp_q.pop_front();
        if (step_count !== mon_exp) begin
          errors++;
          $display("FAIL pulse_count: step_count=%0d, required %0d", step_count, mon_exp);
        end
      end
      checks++;
      if (prev_pe) begin
        errors++;
        $display("FAIL pulse_width: proc_en high on consecutive cycles, required single-cycle");
      end
    end
    prev_pe = (proc_en === 1'b1);
  end

  // driver tasks
  task automatic expect_pulse();
    model_cnt = model_cnt + STEP_W'(1);
    exp_q.push_back(model_cnt);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: %0d expected pulses not seen, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input logic run_mode);
    @(negedge clk);
    Key = 1'b0; divclock = 1'b0; step_key = 1'b1; halt = 1'b0; mode = run_mode;
    #1;
    checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL reset_proc_en: got %b, required 0", proc_en); end
    checks++; if (step_count !== '0) begin errors++; $display("FAIL reset_step_count: got %0d, required 0", step_count); end
    checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL reset_ledr: got %b, required 0100", LEDR); end
    wait_neg(2);
    Key = 1'b1;
    model_cnt = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    wait_neg(3);
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL reset_state_idle: got %b, required 00", LEDR[1:0]); end
    check_drained("reset");
  endtask

  task automatic test_run();
    do_reset(1'b1);
    wait_neg(2);
    checks++; if (LEDR[1:0] !== 2'b01) begin errors++; $display("FAIL run_state: got %b, required 01", LEDR[1:0]); end
    for (int p = 0; p < 5; p++) begin
      divclock = 1'b1;
      expect_pulse();
      wait_neg(2);
      checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL run_early: period %0d proc_en=%b, required 0", p, proc_en); end
      wait_neg(1);
      checks++; if (proc_en !== 1'b1) begin errors++; $display("FAIL run_pulse: period %0d proc_en=%b, required 1", p, proc_en); end
      wait_neg(1);
      checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL run_width: period %0d proc_en=%b, required 0", p, proc_en); end
      wait_neg(6);
      divclock = 1'b0;
      wait_neg(10);
    end
    checks++; if (step_count !== 4'd5) begin errors++; $display("FAIL run_step_count: got %0d, required 5", step_count); end
    check_drained("run");
  endtask

  task automatic test_step_debounce();
    do_reset(1'b0);
    wait_neg(2);
    for (int i = 0; i < 4; i++) begin
      step_key = (i % 2 == 1);
      wait_neg(2);
    end
    step_key = 1'b0;
    expect_pulse();
    wait_neg(6);
    checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL step_early: proc_en=%b, required 0", proc_en); end
    wait_neg(1);
    checks++; if (proc_en !== 1'b1) begin errors++; $display("FAIL step_pulse: proc_en=%b, required 1", proc_en); end
    checks++; if (LEDR[2] !== 1'b0) begin errors++; $display("FAIL step_key_level: got %b, required 0", LEDR[2]); end
    wait_neg(3);
    step_key = 1'b1;
    wait_neg(12);
    checks++; if (LEDR[2] !== 1'b1) begin errors++; $display("FAIL step_release_level: got %b, required 1", LEDR[2]); end
    checks++; if (step_count !== 4'd1) begin errors++; $display("FAIL step_count: got %0d, required 1", step_count); end
    check_drained("step");
  endtask

  task automatic test_stop_halt_press();
    do_reset(1'b0);
    halt = 1'b1;
    wait_neg(2);
    step_key = 1'b0;
    expect_pulse();
    wait_neg(10);
    step_key = 1'b1;
    wait_neg(10);
    checks++; if (step_count !== 4'd1) begin errors++; $display("FAIL stop_halt_count: got %0d, required 1", step_count); end
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL stop_halt_state: got %b, required 00", LEDR[1:0]); end
    halt = 1'b0;
    check_drained("stop_halt");
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    wait_neg(2);
    divclock = 1'b1;
    wait_neg(2);
    halt = 1'b1;
    wait_neg(1);
    checks++; if (LEDR[1:0] !== 2'b10) begin errors++; $display("FAIL halt_state: got %b, required 10", LEDR[1:0]); end
    checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL halt_no_pulse: proc_en=%b, required 0", proc_en); end
    wait_neg(6);
    divclock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_neg(4); divclock = 1'b1;
      wait_neg(4); divclock = 1'b0;
    end
    halt = 1'b0;
    wait_neg(4);
    checks++; if (LEDR[1:0] !== 2'b10) begin errors++; $display("FAIL halt_sticky: got %b, required 10", LEDR[1:0]); end
    mode = 1'b0;
    wait_neg(1);
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL halt_exit: got %b, required 00", LEDR[1:0]); end
    checks++; if (step_count !== 4'd0) begin errors++; $display("FAIL halt_count: got %0d, required 0", step_count); end
    check_drained("halt");
  endtask

  task automatic test_mode_vs_tick();
    do_reset(1'b1);
    wait_neg(2);
    divclock = 1'b1;
    wait_neg(2);
    mode = 1'b0;
    wait_neg(1);
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL mode_tick_state: got %b, required 00", LEDR[1:0]); end
    checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL mode_tick_pulse: proc_en=%b, required 0", proc_en); end
    wait_neg(4);
    divclock = 1'b0;
    wait_neg(4);
    check_drained("mode_tick");
  endtask

  task automatic test_back_to_back_wrap();
    do_reset(1'b1);
    wait_neg(2);
    for (int i = 0; i < 15; i++) begin
      divclock = 1'b1;
      expect_pulse();
      wait_neg(2);
      divclock = 1'b0;
      wait_neg(2);
    end
    wait_neg(4);
    checks++; if (step_count !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d, required 15", step_count); end
    divclock = 1'b1;
    expect_pulse();
    wait_neg(4);
    divclock = 1'b0;
    wait_neg(2);
    checks++; if (step_count !== 4'd0) begin errors++; $display("FAIL wrap_post: got %0d, required 0", step_count); end
    check_drained("wrap");
  endtask

  task automatic test_reset_mid_pulse();
    do_reset(1'b1);
    wait_neg(2);
    divclock = 1'b1;
    expect_pulse();
    wait_neg(3);
    checks++; if (proc_en !== 1'b1) begin errors++; $display("FAIL midpulse_pre: proc_en=%b, required 1", proc_en); end
    #1 Key = 1'b0;
    #1;
    checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL midpulse_proc_en: got %b, required 0", proc_en); end
    checks++; if (step_count !== '0) begin errors++; $display("FAIL midpulse_count: got %0d, required 0", step_count); end
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL midpulse_state: got %b, required 00", LEDR[1:0]); end
    divclock = 1'b0;
    mode = 1'b0;
    wait_neg(2);
    Key = 1'b1;
    model_cnt = '0;
    check_drained("midpulse");
  endtask

  task automatic test_stop_divclock();
    logic h1, h2, v;
    do_reset(1'b0);
    h1 = 1'b0; h2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (LEDR[3] !== h2) begin errors++; $display("FAIL div_follow: cycle %0d got %b, required %b", i, LEDR[3], h2); end
      checks++; if (proc_en !== 1'b0) begin errors++; $display("FAIL stop_div_pulse: cycle %0d proc_en=%b, required 0", i, proc_en); end
      v = 1'($urandom_range(0, 1));
      h2 = h1;
      h1 = v;
      divclock = v;
    end
    checks++; if (LEDR[1:0] !== 2'b00) begin errors++; $display("FAIL stop_div_state: got %b, required 00", LEDR[1:0]); end
    divclock = 1'b0;
    wait_neg(4);
    check_drained("stop_div");
  endtask

  initial begin
    Key = 1'b0; divclock = 1'b0; step_key = 1'b1; mode = 1'b0; halt = 1'b0;
    test_reset();
    test_run();
    test_step_debounce();
    test_stop_halt_press();
    test_halt();
    test_mode_vs_tick();
    test_back_to_back_wrap();
    test_reset_mid_pulse();
    test_stop_divclock();
    wait_neg(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
